addr_scan_ctrl: RTL and testbench

ADDR_SCAN_CTRL -- requirements
Module: addr_scan_ctrl

---
 rtl/addr_scan_ctrl.sv | 146 ++++++++++++++
 tb/tb_addr_scan_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/addr_scan_ctrl.sv
// addr_scan_ctrl
// Sequences one read scan over an address range of a sample RAM. It drives
// an external loadable address counter (le/d/ce) and issues one rd_en
// strobe per address, pacing the scan with the downstream rdy signal. After
// the last strobe it waits RD_LAT cycles so the final data_vld can leave the
// read pipeline. Then it pulses done.
//
// Handshake: a sample moves on a cycle when rd_en=1. In RUN, rd_en equals
// rdy, so the downstream's rdy acts as the ready and the controller is
// always valid while in RUN. The counter only advances (ce) on a cycle that
// moved a sample. So the address holds while rdy=0.
//
// Ports
//   clk, clr          clock; synchronous active-high reset
//   start, abort      scan request (IDLE only); scan termination
//   addr_start/end    inclusive scan range; the range may wrap through 0
//   q                 current address from the external counter
//   rdy               downstream can take one sample this cycle
//   le, d, ce         load-enable, load value, count-enable to the counter
//   rd_en, data_vld   RAM read strobe and its RD_LAT-delayed valid
//   busy, done        not-IDLE flag; one-cycle completion pulse
//   sample_cnt        strobes issued in the current or last scan
//   dbg_state         FSM state for observation
module addr_scan_ctrl #(
  parameter int bit_addr = 9,
  parameter int RD_LAT   = 1
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                start,
  input  logic                abort,
  input  logic [bit_addr-1:0] addr_start,
  input  logic [bit_addr-1:0] addr_end,
  input  logic [bit_addr-1:0] q,
  input  logic                rdy,
  output logic                le,
  output logic [bit_addr-1:0] d,
  output logic                ce,
  output logic                rd_en,
  output logic                data_vld,
  output logic                busy,
  output logic                done,
  output logic [bit_addr:0]   sample_cnt,
  output logic [2:0]          dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [2:0] LAT_M1 = 3'(RD_LAT - 1);

  state_t              state_q, state_d;
  logic [bit_addr-1:0] s_q, s_d;
  logic [bit_addr-1:0] e_q, e_d;
  logic [bit_addr:0]   cnt_q, cnt_d;
  logic [2:0]          drain_q, drain_d;
  logic [RD_LAT-1:0]   vld_q, vld_d;
  logic                kill;

  // A reset that is asserted mid-scan squashes the strobes combinationally,
  // in the same way as abort.
  assign kill = abort | clr;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    e_d     = e_q;
    cnt_d   = cnt_q;
    drain_d = '0;
    le      = 1'b0;
    ce      = 1'b0;
    rd_en   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          s_d     = addr_start;
          e_d     = addr_end;
          cnt_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        le      = !kill;
        state_d = S_RUN;
      end
      S_RUN: begin
        rd_en = rdy && !kill;
        if (rd_en) begin
          // Compare the address being read now against the end address. The
          // counter wraps by itself, so a wrapped range needs no special case.
          if (q == e_q) state_d = S_DRAIN;
          else          ce      = 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_q == LAT_M1) state_d = S_DONE;
        else                   drain_d = drain_q + 3'd1;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (rd_en) cnt_d = cnt_q + 1'b1;

    if (abort) begin
      state_d = S_IDLE;
      drain_d = '0;
    end

    vld_d[0] = rd_en;
    for (int i = 1; i < RD_LAT; i++) vld_d[i] = vld_q[i-1];
    if (abort) vld_d = '0;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      s_q     <= '0;
      e_q     <= '0;
      cnt_q   <= '0;
      drain_q <= '0;
      vld_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      e_q     <= e_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      vld_q   <= vld_d;
    end
  end

  assign d          = s_q;
  assign data_vld   = vld_q[RD_LAT-1];
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE) && !kill;
  assign sample_cnt = cnt_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_addr_scan_ctrl.sv
// Bench for addr_scan_ctrl. It runs two instances side by side: dut_a uses
// RD_LAT=1 and dut_b uses RD_LAT=2. Each instance has its own model of the
// external address counter. Directed steps run in one initial block.
module tb_addr_scan_ctrl;

  logic       clk = 1'b0;
  logic       clr, start, abort, rdy;
  logic [8:0] addr_start, addr_end;

  logic [8:0] q_a = '0, q_b = '0;
  logic       le_a, ce_a, rd_en_a, data_vld_a, busy_a, done_a;
  logic       le_b, ce_b, rd_en_b, data_vld_b, busy_b, done_b;
  logic [8:0] d_a, d_b;
  logic [9:0] sample_cnt_a, sample_cnt_b;
  logic [2:0] dbg_a, dbg_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rdy_mode = 0;

  logic [8:0] exp_q[$];
  logic [8:0] rd_log_a[$], rd_log_b[$];
  int rd_cyc_a[$], rd_cyc_b[$], vld_cyc_a[$], vld_cyc_b[$];
  int done_cnt_a, done_cnt_b, done_cyc_a, done_cyc_b;
  int ce_cnt_a, ce_cnt_b, ce_bad_a, ce_bad_b, le_cnt_a, le_cnt_b;
  logic [8:0] le_d_a, le_d_b;

  // Clock and the external address counters
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (le_a)      q_a <= d_a;
    else if (ce_a) q_a <= q_a + 9'd1;
    if (le_b)      q_b <= d_b;
    else if (ce_b) q_b <= q_b + 9'd1;
  end

  addr_scan_ctrl #(.bit_addr(9), .RD_LAT(1)) dut_a (
    .clk(clk), .clr(clr), .start(start), .abort(abort),
    .addr_start(addr_start), .addr_end(addr_end), .q(q_a), .rdy(rdy),
    .le(le_a), .d(d_a), .ce(ce_a), .rd_en(rd_en_a), .data_vld(data_vld_a),
    .busy(busy_a), .done(done_a), .sample_cnt(sample_cnt_a), .dbg_state(dbg_a)
  );

  addr_scan_ctrl #(.bit_addr(9), .RD_LAT(2)) dut_b (
    .clk(clk), .clr(clr), .start(start), .abort(abort),
    .addr_start(addr_start), .addr_end(addr_end), .q(q_b), .rdy(rdy),
    .le(le_b), .d(d_b), .ce(ce_b), .rd_en(rd_en_b), .data_vld(data_vld_b),
    .busy(busy_b), .done(done_b), .sample_cnt(sample_cnt_b), .dbg_state(dbg_b)
  );

  // Monitors sample on the falling edge
  always @(negedge clk) begin
    if (rd_en_a) begin rd_log_a.push_back(q_a); rd_cyc_a.push_back(cyc); end
    if (rd_en_b) begin rd_log_b.push_back(q_b); rd_cyc_b.push_back(cyc); end
    if (data_vld_a) vld_cyc_a.push_back(cyc);
    if (data_vld_b) vld_cyc_b.push_back(cyc);
    if (done_a) begin done_cnt_a++; done_cyc_a = cyc; end
    if (done_b) begin done_cnt_b++; done_cyc_b = cyc; end
    if (ce_a) ce_cnt_a++;
    if (ce_b) ce_cnt_b++;
    if (ce_a && !rdy) ce_bad_a++;
    if (ce_b && !rdy) ce_bad_b++;
    if (le_a) begin le_cnt_a++; le_d_a = d_a; end
    if (le_b) begin le_cnt_b++; le_d_b = d_b; end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    case (rdy_mode)
      1:       rdy = cyc[0];
      2:       rdy = (cyc % 3) != 0;
      default: rdy = 1'b1;
    endcase
    #1;
  endtask

  task automatic chk(string tag, int obs, int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    rd_log_a.delete(); rd_log_b.delete();
    rd_cyc_a.delete(); rd_cyc_b.delete();
    vld_cyc_a.delete(); vld_cyc_b.delete();
    done_cnt_a = 0; done_cnt_b = 0; done_cyc_a = -1; done_cyc_b = -1;
    ce_cnt_a = 0; ce_cnt_b = 0; ce_bad_a = 0; ce_bad_b = 0;
    le_cnt_a = 0; le_cnt_b = 0; le_d_a = '0; le_d_b = '0;
  endtask

  task automatic wait_idle(int budget);
    int n = 0;
    while ((busy_a || busy_b) && n < budget) begin tick(); n++; end
    chk("idle_timeout", int'(busy_a || busy_b), 0);
  endtask

  // Scoreboard check of one instance against exp_q
  task automatic check_dut(string tag, int lat, logic [8:0] log[$], int rcyc[$],
                           int vcyc[$], int dcnt, int dcyc, int cec, int ceb,
                           int lec, logic [8:0] led, int scnt, logic [8:0] s);
    int errs;
    int n;
    n = exp_q.size();
    errs = (log.size() != n) ? 1 : 0;
    for (int i = 0; i < n && i < log.size(); i++)
      if (log[i] !== exp_q[i]) errs++;
    chk({tag, "_addr_seq"}, errs, 0);
    chk({tag, "_sample_cnt"}, scnt, n);
    chk({tag, "_done_cnt"}, dcnt, 1);
    chk({tag, "_le_cnt"}, lec, 1);
    chk({tag, "_le_d"}, int'(led), int'(s));
    chk({tag, "_ce_cnt"}, cec, n - 1);
    chk({tag, "_ce_no_rdy"}, ceb, 0);
    errs = (vcyc.size() != rcyc.size()) ? 1 : 0;
    for (int i = 0; i < vcyc.size() && i < rcyc.size(); i++)
      if (vcyc[i] != rcyc[i] + lat) errs++;
    chk({tag, "_vld_lat"}, errs, 0);
    chk({tag, "_drain_len"},
        (rcyc.size() > 0) ? dcyc - rcyc[rcyc.size()-1] : -1, lat + 1);
  endtask

  task automatic run_scan(string tag, logic [8:0] s, logic [8:0] e, int mode);
    logic [8:0] diff;
    clear_logs();
    rdy_mode   = mode;
    addr_start = s;
    addr_end   = e;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    // Range inputs change after acceptance and a second start arrives while
    // busy; neither may disturb the scan.
    addr_start = 9'($urandom_range(0, 511));
    addr_end   = 9'($urandom_range(0, 511));
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle(3000);
    tick();
    diff = e - s;
    exp_q.delete();
    for (int i = 0; i <= int'(diff); i++) exp_q.push_back(s + 9'(i));
    check_dut({tag, "_a"}, 1, rd_log_a, rd_cyc_a, vld_cyc_a, done_cnt_a, done_cyc_a,
              ce_cnt_a, ce_bad_a, le_cnt_a, le_d_a, int'(sample_cnt_a), s);
    check_dut({tag, "_b"}, 2, rd_log_b, rd_cyc_b, vld_cyc_b, done_cnt_b, done_cyc_b,
              ce_cnt_b, ce_bad_b, le_cnt_b, le_d_b, int'(sample_cnt_b), s);
    rdy_mode = 0;
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_le"},       int'(le_a | le_b), 0);
    chk({tag, "_ce"},       int'(ce_a | ce_b), 0);
    chk({tag, "_rd_en"},    int'(rd_en_a | rd_en_b), 0);
    chk({tag, "_data_vld"}, int'(data_vld_a | data_vld_b), 0);
    chk({tag, "_busy"},     int'(busy_a | busy_b), 0);
    chk({tag, "_done"},     int'(done_a | done_b), 0);
    chk({tag, "_d"},        int'(d_a | d_b), 0);
    chk({tag, "_cnt"},      int'(sample_cnt_a | sample_cnt_b), 0);
    chk({tag, "_state"},    int'(dbg_a | dbg_b), 0);
  endtask

  initial begin
    clr = 1'b1; start = 1'b1; abort = 1'b0; rdy = 1'b1;
    addr_start = 9'd55; addr_end = 9'd66;
    clear_logs();

    // Reset wins over a simultaneous start
    tick(); tick();
    check_reset_outputs("reset");
    clr = 1'b0; start = 1'b0;
    tick();

    // abort and start in the same IDLE cycle: abort wins
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("abort_vs_start_busy", int'(busy_a | busy_b), 0);
    tick();

    run_scan("basic", 9'd10, 9'd13, 0);
    run_scan("wrap", 9'd510, 9'd1, 0);
    run_scan("single", 9'd7, 9'd7, 1);
    run_scan("full", 9'd0, 9'd511, 2);

    // Abort on the third RUN cycle
    clear_logs();
    addr_start = 9'd20; addr_end = 9'd40; start = 1'b1;
    tick();                  // LOAD
    start = 1'b0;
    tick();                  // RUN 1 reads 20
    tick();                  // RUN 2 reads 21
    tick();                  // RUN 3
    abort = 1'b1;
    #1;
    chk("abort_rd_en", int'(rd_en_a | rd_en_b), 0);
    chk("abort_ce", int'(ce_a | ce_b), 0);
    tick();
    abort = 1'b0;
    chk("abort_idle", int'(busy_a | busy_b), 0);
    for (int i = 0; i < 6; i++) tick();
    chk("abort_rd_a", rd_log_a.size(), 2);
    chk("abort_rd_b", rd_log_b.size(), 2);
    chk("abort_vld_a", vld_cyc_a.size(), 2);
    chk("abort_vld_b", vld_cyc_b.size(), 1);
    chk("abort_done", done_cnt_a + done_cnt_b, 0);
    chk("abort_cnt_b", int'(sample_cnt_b), 2);
    run_scan("after_abort", 9'd3, 9'd5, 0);

    // Reset mid-RUN, then a fresh scan
    clear_logs();
    addr_start = 9'd100; addr_end = 9'd200; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    clr = 1'b1;
    #1;
    chk("clr_rd_en_comb", int'(rd_en_a | rd_en_b), 0);
    tick();
    check_reset_outputs("clr_run");
    start = 1'b1;
    tick();
    check_reset_outputs("clr_hold");
    clr = 1'b0; start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("clr_no_resume", int'(busy_a | busy_b), 0);
    run_scan("after_clr", 9'd30, 9'd33, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
